// File: rtl/tpu_pkg.sv
// Shared constants and state encoding for the TPU job sequencer slice.
package tpu_pkg;

  localparam int N_ELEMS   = 8;  // a00..a11 followed by b00..b11
  localparam int N_RESULTS = 4;  // c00, c01, c10, c11

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

endpackage

// File: rtl/tpu_out_serializer.sv
// Splits the four MMU results into a stream of eight bytes, low byte first.
module tpu_out_serializer
  import tpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  input  logic              clear,
  input  logic              out_ready,
  input  logic [ACC_W-1:0]  res_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        res_sel,
  output logic              drain_last
);

  logic [2:0] idx;
  logic       fire;

  assign out_valid  = active;
  assign fire       = active & out_ready;
  assign drain_last = fire && (idx == 3'(2 * N_RESULTS - 1));
  assign res_sel    = idx[2:1];
  // Outside DRAIN the byte lane is forced to zero so nothing leaks from the MMU.
  assign out_data   = !active ? '0 :
                      idx[0]  ? res_data[ACC_W-1 -: DATA_W] : res_data[DATA_W-1:0];

  // Byte index advances only on an accepted byte; the 7->0 wrap ends the job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 3'd0;
    end else if (clear) begin
      idx <= 3'd0;
    end else if (fire) begin
      idx <= idx + 3'd1;
    end
  end

endmodule

// File: rtl/tpu_job_sequencer.sv
// Sequences one 2x2 matrix-multiply job: load 8 elements into matrix memory,
// clear the accumulators, run the MMU, then stream the 4 results as 8 bytes.
module tpu_job_sequencer
  import tpu_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ACC_W          = 2 * DATA_W,
  parameter int COMPUTE_CYCLES = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              mem_we,
  output logic [2:0]        mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mmu_clear,
  output logic              mmu_en,
  output logic [2:0]        mmu_cycle,
  output logic [1:0]        res_sel,
  input  logic [ACC_W-1:0]  res_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  state_t     state, state_nxt;
  logic [2:0] elem_cnt;
  logic [2:0] cyc;
  logic       accept;
  logic       load_last;
  logic       compute_last;
  logic       drain_last;

  // in_ready is gated by rst_n so it reads 0 for the whole reset interval.
  assign in_ready     = rst_n & ((state == ST_IDLE) | (state == ST_LOAD));
  assign accept       = in_valid & in_ready;
  assign load_last    = accept && (elem_cnt == 3'(N_ELEMS - 1));
  assign compute_last = (state == ST_COMPUTE) && (cyc == 3'(COMPUTE_CYCLES - 1));
  assign busy         = (state != ST_IDLE);
  assign mmu_clear    = (state == ST_CLEAR);
  assign mmu_en       = (state == ST_COMPUTE);
  assign mmu_cycle    = mmu_en ? cyc : 3'd0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept)       state_nxt = ST_LOAD;
      ST_LOAD:    if (load_last)    state_nxt = ST_CLEAR;
      ST_CLEAR:                     state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (compute_last) state_nxt = ST_DRAIN;
      ST_DRAIN:   if (drain_last)   state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  // Element and compute-cycle counters; both drop to zero on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_cnt <= 3'd0;
      cyc      <= 3'd0;
    end else begin
      if (abort) begin
        elem_cnt <= 3'd0;
      end else if (accept) begin
        elem_cnt <= elem_cnt + 3'd1;
      end
      if (mmu_en && !compute_last && !abort) begin
        cyc <= cyc + 3'd1;
      end else begin
        cyc <= 3'd0;
      end
    end
  end

  // Memory write port is one cycle behind the handshake; an aborted
  // handshake never reaches the memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_waddr <= 3'd0;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept & ~abort;
      if (accept && !abort) begin
        mem_waddr <= elem_cnt;
        mem_wdata <= in_data;
      end
    end
  end

  // Job-complete pulse on the cycle after the last byte is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else begin
      done <= drain_last & ~abort;
    end
  end

  tpu_out_serializer #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .active     (state == ST_DRAIN),
    .clear      (abort),
    .out_ready  (out_ready),
    .res_data   (res_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .res_sel    (res_sel),
    .drain_last (drain_last)
  );

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// Bench for tpu_job_sequencer: job-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_tpu_job_sequencer;

  localparam int CC  = 6;
  localparam int CC2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, abort, in_valid, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, mmu_clear, mmu_en, out_valid, busy, done;
  logic [2:0]  mem_waddr, mmu_cycle;
  logic [7:0]  mem_wdata, out_data;
  logic [1:0]  res_sel;
  logic [15:0] res_data;

  logic        abort2, in_valid2, out_ready2;
  logic [7:0]  in_data2;
  logic        in_ready2, mem_we2, mmu_clear2, mmu_en2, out_valid2, busy2, done2;
  logic [2:0]  mem_waddr2, mmu_cycle2;
  logic [7:0]  mem_wdata2, out_data2;
  logic [1:0]  res_sel2;
  logic [15:0] res_data2;

  tpu_job_sequencer #(.DATA_W(8), .ACC_W(16), .COMPUTE_CYCLES(CC)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mmu_clear(mmu_clear), .mmu_en(mmu_en), .mmu_cycle(mmu_cycle), .res_sel(res_sel),
    .res_data(res_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done));

  tpu_job_sequencer #(.DATA_W(8), .ACC_W(16), .COMPUTE_CYCLES(CC2)) dut2 (
    .clk(clk), .rst_n(rst_n), .abort(abort2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .mem_we(mem_we2), .mem_waddr(mem_waddr2), .mem_wdata(mem_wdata2),
    .mmu_clear(mmu_clear2), .mmu_en(mmu_en2), .mmu_cycle(mmu_cycle2), .res_sel(res_sel2),
    .res_data(res_data2), .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .busy(busy2), .done(done2));

  assign res_data2 = 16'hA55A;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Matrix memory + MMU stand-in: C = A*B from whatever the DUT wrote.
  logic [7:0] tmem [8];
  logic [2:0] ia0, ia1, ib0, ib1;
  initial for (int i = 0; i < 8; i++) tmem[i] = 8'd0;
  always @(posedge clk) if (mem_we) tmem[mem_waddr] <= mem_wdata;
  always_comb begin
    ia0 = {1'b0, res_sel[1], 1'b0};
    ia1 = {1'b0, res_sel[1], 1'b1};
    ib0 = {2'b10, res_sel[0]};
    ib1 = {2'b11, res_sel[0]};
    res_data = 16'(tmem[ia0]) * 16'(tmem[ib0]) + 16'(tmem[ia1]) * 16'(tmem[ib1]);
  end

  // ---------------- job-level model ----------------
  // n_loaded: elements accepted in this job; t: cycles since the 8th element
  // (0 = not full yet); n_out: bytes accepted by the consumer.
  int         n_loaded, t, n_out;
  logic [7:0] m_e [8];
  logic       e_we, e_done;
  logic [2:0] e_waddr;
  logic [7:0] e_wdata;

  function automatic logic [7:0] exp_byte(input int b);
    int r, i, j;
    logic [15:0] c;
    r = b / 2; i = r / 2; j = r % 2;
    c = 16'(m_e[2*i]) * 16'(m_e[4+j]) + 16'(m_e[2*i+1]) * 16'(m_e[6+j]);
    return (b % 2 == 1) ? c[15:8] : c[7:0];
  endfunction

  task automatic model_reset();
    n_loaded = 0; t = 0; n_out = 0; e_we = 1'b0; e_done = 1'b0;
  endtask

  task automatic model_compare();
    logic x_en, x_ov;
    x_en = (t >= 2) && (t <= CC + 1);
    x_ov = (t >= CC + 2);
    chk("in_ready", in_ready, (rst_n && t == 0) ? 1 : 0);
    chk("busy", busy, (n_loaded != 0) ? 1 : 0);
    chk("mmu_clear", mmu_clear, (t == 1) ? 1 : 0);
    chk("mmu_en", mmu_en, x_en ? 1 : 0);
    chk("mmu_cycle", mmu_cycle, x_en ? 32'(t - 2) : 0);
    chk("out_valid", out_valid, x_ov ? 1 : 0);
    chk("res_sel", res_sel, 32'(n_out / 2));
    chk("out_data", out_data, x_ov ? 32'(exp_byte(n_out)) : 0);
    chk("mem_we", mem_we, e_we ? 1 : 0);
    if (e_we) begin
      chk("mem_waddr", mem_waddr, 32'(e_waddr));
      chk("mem_wdata", mem_wdata, 32'(e_wdata));
    end
    chk("done", done, e_done ? 1 : 0);
  endtask

  // Advance the model by the clock edge that follows this negedge.
  task automatic model_step();
    logic hs, ohs;
    hs  = in_valid && (t == 0);
    ohs = (t >= CC + 2) && out_ready;
    e_done = 1'b0;
    e_we   = 1'b0;
    if (abort) begin
      n_loaded = 0; t = 0; n_out = 0;
    end else if (hs) begin
      e_we = 1'b1; e_waddr = 3'(n_loaded); e_wdata = in_data;
      m_e[n_loaded] = in_data;
      n_loaded++;
      if (n_loaded == 8) t = 1;
    end else if (t != 0 && t < CC + 2) begin
      t++;
    end else if (ohs) begin
      n_out++;
      if (n_out == 8) begin
        e_done = 1'b1; n_loaded = 0; t = 0; n_out = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      model_compare();
      if (rst_n) model_step();
    end
  end

  // ---------------- monitors ----------------
  logic [10:0] wq [$];
  logic [7:0]  bq [$];
  logic [2:0]  cq2 [$];
  int n_clr, n_en, n_done, n_done2;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) wq.push_back({mem_waddr, mem_wdata});
      if (mmu_clear) n_clr++;
      if (mmu_en) n_en++;
      if (done) n_done++;
      if (out_valid && out_ready) bq.push_back(out_data);
      if (mmu_en2) cq2.push_back(mmu_cycle2);
      if (done2) n_done2++;
    end
  end

  task automatic clear_mon();
    wq.delete(); bq.delete(); cq2.delete();
    n_clr = 0; n_en = 0; n_done = 0; n_done2 = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  logic [7:0] job_e [8];
  logic [7:0] exp_b [8];
  int hs_edge;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
    hs_edge = cyc_n;
  endtask

  task automatic load_job(input bit gaps);
    for (int i = 0; i < 8; i++) begin
      send(job_e[i]);
      if (gaps) tick();
    end
  endtask

  task automatic wait_out_valid(output int lat);
    bit ok = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; lat = cyc_n - hs_edge; break; end
    end
    if (!ok) timeout_fail("wait_out_valid");
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) timeout_fail("wait_done");
    tick();
    tick();
  endtask

  task automatic check_bytes(input string tag);
    chk($sformatf("%s_nbytes", tag), bq.size(), 8);
    for (int i = 0; i < 8 && i < bq.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), bq[i], exp_b[i]);
  endtask

  task automatic check_writes(input string tag);
    chk($sformatf("%s_nwrites", tag), wq.size(), 8);
    for (int i = 0; i < 8 && i < wq.size(); i++)
      chk($sformatf("%s_write%0d", tag, i), wq[i], {3'(i), job_e[i]});
  endtask

  task automatic set_job_ab();
    for (int i = 0; i < 8; i++) job_e[i] = 8'(i + 1);
    exp_b = '{8'd19, 8'd0, 8'd22, 8'd0, 8'd43, 8'd0, 8'd50, 8'd0};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit ok;
    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    abort2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", in_ready, 1);

    // Back-to-back load, no backpressure.
    set_job_ab();
    clear_mon();
    out_ready = 1'b1;
    load_job(1'b0);
    wait_out_valid(lat);
    chk("t1_latency", lat, CC + 1);
    wait_done();
    check_writes("t1");
    check_bytes("t1");
    chk("t1_clear_cycles", n_clr, 1);
    chk("t1_en_cycles", n_en, CC);
    chk("t1_done_count", n_done, 1);

    // in_valid every other cycle.
    clear_mon();
    load_job(1'b1);
    wait_done();
    check_writes("t2");
    check_bytes("t2");
    chk("t2_done_count", n_done, 1);

    // Consumer stalls for 3 cycles at byte index 3.
    clear_mon();
    out_ready = 1'b0;
    load_job(1'b0);
    wait_out_valid(lat);
    tick();
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall_valid", out_valid, 1);
      chk("t3_stall_data", out_data, 0);
      chk("t3_stall_sel", res_sel, 1);
      tick();
    end
    out_ready = 1'b1;
    wait_done();
    check_bytes("t3");
    chk("t3_done_count", n_done, 1);

    // Abort on the 5th handshake, then a clean job.
    clear_mon();
    for (int i = 0; i < 4; i++) send(8'(i + 1));
    in_valid = 1'b1; in_data = 8'd5; abort = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_mem_we", mem_we, 0);
    chk("t4_nwrites", wq.size(), 4);
    repeat (3) tick();
    chk("t4_no_done", n_done, 0);
    clear_mon();
    job_e = '{8'd200, 8'd3, 8'd17, 8'd9, 8'd11, 8'd250, 8'd6, 8'd128};
    exp_b = '{8'd170, 8'd8, 8'd208, 8'd196, 8'd241, 8'd0, 8'd26, 8'd21};
    load_job(1'b0);
    wait_done();
    check_writes("t4");
    check_bytes("t4");
    chk("t4_done_count", n_done, 1);

    // Reset pulse while computing.
    set_job_ab();
    clear_mon();
    load_job(1'b0);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mmu_en) begin ok = 1'b1; break; end
    end
    if (!ok) timeout_fail("t5_wait_compute");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_in_ready", in_ready, 0);
    chk("t5_busy", busy, 0);
    chk("t5_mmu_en", mmu_en, 0);
    chk("t5_mmu_cycle", mmu_cycle, 0);
    chk("t5_mmu_clear", mmu_clear, 0);
    chk("t5_mem_we", mem_we, 0);
    chk("t5_mem_waddr", mem_waddr, 0);
    chk("t5_mem_wdata", mem_wdata, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_data", out_data, 0);
    chk("t5_res_sel", res_sel, 0);
    chk("t5_done", done, 0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_no_done", n_done, 0);
    clear_mon();
    load_job(1'b0);
    wait_done();
    check_bytes("t5");
    chk("t5_done_count", n_done, 1);

    // COMPUTE_CYCLES = 2 instance.
    clear_mon();
    out_ready2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid2 = 1'b1; in_data2 = 8'(i + 1);
      tick();
    end
    in_valid2 = 1'b0;
    hs_edge = cyc_n;
    ok = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid2) begin ok = 1'b1; lat = cyc_n - hs_edge; break; end
    end
    if (!ok) timeout_fail("t6_wait_out_valid");
    chk("t6_latency", lat, 3);
    chk("t6_first_byte", out_data2, 8'h5A);
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done2) begin ok = 1'b1; break; end
    end
    if (!ok) timeout_fail("t6_wait_done");
    tick();
    tick();
    chk("t6_ncycles", cq2.size(), 2);
    if (cq2.size() == 2) begin
      chk("t6_cycle0", cq2[0], 0);
      chk("t6_cycle1", cq2[1], 1);
    end
    chk("t6_done_count", n_done2, 1);
    chk("t6_idle", busy2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
